add_rs: RTL and testbench
=========================

# add_rs

Adder-class reservation station bank for the Tomasulo core: the receiving end of the issue stage's adder-class issue interface (addq/subq, beq, jmp). It advertises a free entry tag to issue, captures operands or producer tags, snoops the common data bus (CDB), and dispatches ready entries to the integer adder functional unit. Each entry stays allocated until the CDB broadcasts that entry's own tag, so the tag is never reused while consumers still wait on it.

## Interface
Parameters:
- NUM_ENT, 3, number of entries.
- TAG_BASE, 1, tag of entry 0; entry i owns tag TAG_BASE+i (add_1..add_3 = 1..3).
- TAG_W, 4, tag width; tag 0 = notag (operand value valid).
- DATA_W, 64, operand/result width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- issue_valid  in  1  issue stage accepts an adder-class instruction this cycle.
- issue_opcode  in  6  instruction op field.
- issue_funct  in  7  instruction funct field.
- issue_rob_slot  in  2  ROB slot allocated to the instruction.
- src1_tag, src2_tag  in  TAG_W each  producer tags from the register file; 0 = value valid.
- src1_val, src2_val  in  DATA_W each  register file values, meaningful when the matching tag is 0.
- free_tag  out  TAG_W  tag of the lowest-index FREE entry; 0 when all entries are busy.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  CDB producer tag.
- cdb_val  in  DATA_W  CDB result.
- flush  in  1  squash all entries (branch mispredict).
- fu_valid  out  1  an entry is dispatching.
- fu_ready  in  1  adder accepts this cycle.
- fu_opcode, fu_funct  out  6, 7  op and funct of the dispatched entry.
- fu_a, fu_b  out  DATA_W each  operands.
- fu_tag  out  TAG_W  entry tag; the adder broadcasts its result on the CDB with this tag.
- fu_rob_slot  out  2  ROB slot.

## Operation
- Per-entry state: FREE, WAIT (at least one operand tag nonzero), READY (both operands valid), EXEC (dispatched, waiting for own-tag CDB broadcast).
- Issue: issue_valid with free_tag≠0 writes the entry free_tag names. Per operand: tag 0 → store the value. Nonzero tag equal to cdb_tag with cdb_valid set in the same cycle → store cdb_val, tag 0. Otherwise store the tag. The entry enters READY if both operands are resolved, otherwise WAIT.
- issue_valid while free_tag=0 is ignored, with no state change.
- CDB snoop: every WAIT operand whose tag matches a valid cdb_tag captures cdb_val and clears its tag. WAIT→READY when both operands are clear.
- Dispatch: fu_valid=1 when any entry is READY. The lowest-index READY entry drives the fu_* outputs. On fu_valid&fu_ready, that entry goes READY→EXEC. With fu_ready=0 the entry holds and the outputs stay stable.
- Release: cdb_valid with cdb_tag equal to an EXEC entry's tag moves that entry EXEC→FREE.
- flush: all entries go FREE at the next edge. flush overrides issue, CDB and dispatch in the same cycle.
- While fu_valid=0, the fu_* data outputs are 0.

## Timing
- Reset (rst_n=0 at an edge): all entries FREE, free_tag=TAG_BASE, fu_valid=0, all fu_* outputs 0.
- free_tag and fu_* are combinational from registered state only. There is no combinational path from issue_* or cdb_* to any output.
- Latency from issue with both operands valid to fu_valid=1 is 1 cycle.
- A CDB wakeup makes the entry eligible for dispatch 1 cycle later.
- An entry released at edge N shows up in free_tag after edge N, so it can be reissued in cycle N+1, never in the same cycle.
- Simultaneous issue and CDB wakeup of a different entry: both take effect.
- CDB matching both operands of one entry: both are captured.
- Bank full: free_tag=0 until a release occurs.

## Structure
- Shared package tomasulo_pkg holds:
  - the notag/add_1..br tag constants;
  - the opcode and funct constants;
  - the rs_state_t enum {FREE, WAIT, READY, EXEC};
  - a struct for an operand (tag, value).
- Sub-module rs_entry holds one entry's state, operand capture and CDB compare. It exposes ready, busy and its fields.
- add_rs instantiates NUM_ENT copies of rs_entry plus priority encoders for free_tag and dispatch select.

## Test plan
- Reset, then issue addq with src1_tag=src2_tag=0, src1_val=5, src2_val=7, rob_slot=2, fu_ready=1 → next cycle fu_valid=1, fu_a=5, fu_b=7, fu_tag=1, fu_rob_slot=2; free_tag=2.
- Issue with src1_tag=4, then CDB tag 4 value 0x10 two cycles later → fu_valid rises the cycle after the CDB, with fu_a=0x10.
- Fill all 3 entries with fu_ready=0 → free_tag=0, and a 4th issue_valid changes nothing. CDB tag 1 while entry 1 is READY (not EXEC) must not free it.
- Entry 1 in EXEC; CDB tag 1 → free_tag=1 the next cycle. Issue in that cycle reuses tag 1.
- Issue with src2_tag=5 while cdb_valid, cdb_tag=5, cdb_val=9 in the same cycle → entry READY immediately, with fu_b=9.
- flush asserted in the same cycle as issue and CDB, with 2 entries busy → next cycle free_tag=1, fu_valid=0, all entries FREE.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo core.
// Holds the reservation-station tag map, the opcode/funct encodings of the
// adder-class instructions, the per-entry state enum and the operand bundle.
// No ports: imported by the reservation-station modules.
package tomasulo_pkg;

    localparam int TAG_W_DEF  = 4;
    localparam int DATA_W_DEF = 64;

    // Producer tags. Tag 0 means the operand value is already valid.
    localparam logic [3:0] TAG_NOTAG = 4'd0;
    localparam logic [3:0] TAG_ADD_1 = 4'd1;
    localparam logic [3:0] TAG_ADD_2 = 4'd2;
    localparam logic [3:0] TAG_ADD_3 = 4'd3;
    localparam logic [3:0] TAG_MUL_1 = 4'd4;
    localparam logic [3:0] TAG_MUL_2 = 4'd5;
    localparam logic [3:0] TAG_LD_1  = 4'd6;
    localparam logic [3:0] TAG_LD_2  = 4'd7;
    localparam logic [3:0] TAG_BR    = 4'd8;

    // Adder-class instruction encodings.
    localparam logic [5:0] OP_INTA = 6'h10;
    localparam logic [5:0] OP_BEQ  = 6'h39;
    localparam logic [5:0] OP_JMP  = 6'h1A;
    localparam logic [6:0] FN_ADDQ = 7'h20;
    localparam logic [6:0] FN_SUBQ = 7'h29;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2,
        EXEC  = 2'd3
    } rs_state_t;

    typedef struct packed {
        logic [TAG_W_DEF-1:0]  tag;
        logic [DATA_W_DEF-1:0] val;
    } operand_t;

endpackage

// File: rtl/rs_entry.sv
// One adder reservation-station entry.
// Holds the entry state (FREE/WAIT/READY/EXEC), captures operands at issue
// (with same-cycle CDB bypass), snoops the CDB while waiting, moves to EXEC
// when dispatched and returns to FREE when the CDB broadcasts MY_TAG.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   flush             squash the entry
//   alloc             issue writes this entry this cycle
//   issue_*, src*     instruction fields and operand tags/values from issue
//   cdb_*             common data bus broadcast
//   dispatch          the functional unit accepts this entry this cycle
//   ready, busy       state flags; opcode..b are the stored fields
module rs_entry
    import tomasulo_pkg::*;
#(
    parameter int                 TAG_W  = 4,
    parameter int                 DATA_W = 64,
    parameter logic [TAG_W-1:0]   MY_TAG = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              alloc,
    input  logic [5:0]        issue_opcode,
    input  logic [6:0]        issue_funct,
    input  logic [1:0]        issue_rob_slot,
    input  logic [TAG_W-1:0]  src1_tag,
    input  logic [DATA_W-1:0] src1_val,
    input  logic [TAG_W-1:0]  src2_tag,
    input  logic [DATA_W-1:0] src2_val,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_val,
    input  logic              dispatch,
    output logic              ready,
    output logic              busy,
    output logic [5:0]        opcode,
    output logic [6:0]        funct,
    output logic [1:0]        rob_slot,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b
);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } opnd_t;

    rs_state_t         state, state_nxt;
    logic [TAG_W-1:0]  t1, t2;
    logic [DATA_W-1:0] v1, v2;
    opnd_t             op1, op2;
    logic              take_issue;
    logic              data_wr;
    logic              resolved;

    // A pending operand whose producer is on the CDB takes the broadcast value.
    function automatic opnd_t capture(input logic [TAG_W-1:0]  tag,
                                      input logic [DATA_W-1:0] val,
                                      input logic              c_vld,
                                      input logic [TAG_W-1:0]  c_tag,
                                      input logic [DATA_W-1:0] c_val);
        opnd_t r;
        r.tag = tag;
        r.val = val;
        if (tag != '0 && c_vld && tag == c_tag) begin
            r.tag = '0;
            r.val = c_val;
        end
        return r;
    endfunction

    always_comb begin
        take_issue = alloc && (state == FREE);
        op1 = capture(take_issue ? src1_tag : t1, take_issue ? src1_val : v1,
                      cdb_valid, cdb_tag, cdb_val);
        op2 = capture(take_issue ? src2_tag : t2, take_issue ? src2_val : v2,
                      cdb_valid, cdb_tag, cdb_val);
        resolved = (op1.tag == '0) && (op2.tag == '0);
        // Operand registers only change on allocation or while waiting.
        data_wr = !flush && (take_issue || state == WAIT);

        state_nxt = state;
        case (state)
            FREE:    if (take_issue) state_nxt = resolved ? READY : WAIT;
            WAIT:    if (resolved) state_nxt = READY;
            READY:   if (dispatch) state_nxt = EXEC;
            // Hold the tag until our own result is broadcast so no consumer
            // can see it reused while still waiting on it.
            EXEC:    if (cdb_valid && cdb_tag == MY_TAG) state_nxt = FREE;
            default: state_nxt = FREE;
        endcase
        if (flush) state_nxt = FREE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= FREE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (data_wr) begin
            t1 <= op1.tag;
            v1 <= op1.val;
            t2 <= op2.tag;
            v2 <= op2.val;
        end
        if (take_issue && !flush) begin
            opcode   <= issue_opcode;
            funct    <= issue_funct;
            rob_slot <= issue_rob_slot;
        end
    end

    assign ready = (state == READY);
    assign busy  = (state != FREE);
    assign a     = v1;
    assign b     = v2;

endmodule

// File: rtl/add_rs.sv
// Adder-class reservation station bank.
// Advertises the lowest free entry tag to issue, holds NUM_ENT rs_entry
// instances, and dispatches the lowest-index READY entry to the adder.
// All outputs derive from registered entry state only.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   issue_valid/opcode/funct/rob_slot, src1/src2 tag+val   issue interface
//   free_tag                   tag of the lowest free entry, 0 when full
//   cdb_valid/tag/val          common data bus
//   flush                      squash every entry
//   fu_valid, fu_ready         dispatch handshake with the adder
//   fu_opcode/funct/a/b/tag/rob_slot  dispatched entry, zero when idle
module add_rs
    import tomasulo_pkg::*;
#(
    parameter int NUM_ENT  = 3,
    parameter int TAG_BASE = 1,
    parameter int TAG_W    = 4,
    parameter int DATA_W   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [5:0]        issue_opcode,
    input  logic [6:0]        issue_funct,
    input  logic [1:0]        issue_rob_slot,
    input  logic [TAG_W-1:0]  src1_tag,
    input  logic [TAG_W-1:0]  src2_tag,
    input  logic [DATA_W-1:0] src1_val,
    input  logic [DATA_W-1:0] src2_val,
    output logic [TAG_W-1:0]  free_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_val,
    input  logic              flush,
    output logic              fu_valid,
    input  logic              fu_ready,
    output logic [5:0]        fu_opcode,
    output logic [6:0]        fu_funct,
    output logic [DATA_W-1:0] fu_a,
    output logic [DATA_W-1:0] fu_b,
    output logic [TAG_W-1:0]  fu_tag,
    output logic [1:0]        fu_rob_slot
);

    logic [NUM_ENT-1:0] ent_ready, ent_busy;
    logic [NUM_ENT-1:0] free_onehot, disp_onehot;
    logic [NUM_ENT-1:0] ent_alloc, ent_disp;
    logic [5:0]         ent_op  [NUM_ENT];
    logic [6:0]         ent_fn  [NUM_ENT];
    logic [1:0]         ent_rob [NUM_ENT];
    logic [DATA_W-1:0]  ent_a   [NUM_ENT];
    logic [DATA_W-1:0]  ent_b   [NUM_ENT];

    for (genvar g = 0; g < NUM_ENT; g++) begin : g_ent
        rs_entry #(
            .TAG_W  (TAG_W),
            .DATA_W (DATA_W),
            .MY_TAG (TAG_W'(TAG_BASE + g))
        ) u_ent (
            .clk            (clk),
            .rst_n          (rst_n),
            .flush          (flush),
            .alloc          (ent_alloc[g]),
            .issue_opcode   (issue_opcode),
            .issue_funct    (issue_funct),
            .issue_rob_slot (issue_rob_slot),
            .src1_tag       (src1_tag),
            .src1_val       (src1_val),
            .src2_tag       (src2_tag),
            .src2_val       (src2_val),
            .cdb_valid      (cdb_valid),
            .cdb_tag        (cdb_tag),
            .cdb_val        (cdb_val),
            .dispatch       (ent_disp[g]),
            .ready          (ent_ready[g]),
            .busy           (ent_busy[g]),
            .opcode         (ent_op[g]),
            .funct          (ent_fn[g]),
            .rob_slot       (ent_rob[g]),
            .a              (ent_a[g]),
            .b              (ent_b[g])
        );
    end

    // Lowest-index priority encoders for the free slot and the dispatch pick.
    always_comb begin
        logic found_free;
        logic found_rdy;
        found_free  = 1'b0;
        found_rdy   = 1'b0;
        free_onehot = '0;
        disp_onehot = '0;
        free_tag    = TAG_W'(TAG_NOTAG);
        for (int i = 0; i < NUM_ENT; i++) begin
            if (!ent_busy[i] && !found_free) begin
                found_free     = 1'b1;
                free_onehot[i] = 1'b1;
                free_tag       = TAG_W'(TAG_BASE + i);
            end
            if (ent_ready[i] && !found_rdy) begin
                found_rdy      = 1'b1;
                disp_onehot[i] = 1'b1;
            end
        end
    end

    assign ent_alloc = free_onehot & {NUM_ENT{issue_valid}};
    assign ent_disp  = disp_onehot & {NUM_ENT{fu_ready}};
    assign fu_valid  = |ent_ready;

    // Outputs stay zero unless an entry is being presented.
    always_comb begin
        fu_opcode   = '0;
        fu_funct    = '0;
        fu_a        = '0;
        fu_b        = '0;
        fu_tag      = '0;
        fu_rob_slot = '0;
        for (int i = 0; i < NUM_ENT; i++) begin
            if (disp_onehot[i]) begin
                fu_opcode   = ent_op[i];
                fu_funct    = ent_fn[i];
                fu_a        = ent_a[i];
                fu_b        = ent_b[i];
                fu_tag      = TAG_W'(TAG_BASE + i);
                fu_rob_slot = ent_rob[i];
            end
        end
    end

endmodule

// File: tb/tb_add_rs.sv
module tb_add_rs;
    import tomasulo_pkg::*;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic [5:0]  issue_opcode = '0;
    logic [6:0]  issue_funct = '0;
    logic [1:0]  issue_rob_slot = '0;
    logic [3:0]  src1_tag = '0, src2_tag = '0;
    logic [63:0] src1_val = '0, src2_val = '0;
    logic [3:0]  free_tag;
    logic        cdb_valid = 1'b0;
    logic [3:0]  cdb_tag = '0;
    logic [63:0] cdb_val = '0;
    logic        flush = 1'b0;
    logic        fu_valid;
    logic        fu_ready = 1'b0;
    logic [5:0]  fu_opcode;
    logic [6:0]  fu_funct;
    logic [63:0] fu_a, fu_b;
    logic [3:0]  fu_tag;
    logic [1:0]  fu_rob_slot;

    always #5 clk = ~clk;

    add_rs #(.NUM_ENT(3), .TAG_BASE(1), .TAG_W(4), .DATA_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_opcode(issue_opcode),
        .issue_funct(issue_funct), .issue_rob_slot(issue_rob_slot),
        .src1_tag(src1_tag), .src2_tag(src2_tag),
        .src1_val(src1_val), .src2_val(src2_val),
        .free_tag(free_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .flush(flush),
        .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_opcode(fu_opcode), .fu_funct(fu_funct),
        .fu_a(fu_a), .fu_b(fu_b), .fu_tag(fu_tag), .fu_rob_slot(fu_rob_slot)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (entry-level bookkeeping) ----------------
    localparam int S_FREE = 0, S_WAIT = 1, S_READY = 2, S_EXEC = 3;
    int          m_st  [N];
    logic [3:0]  m_t1  [N], m_t2 [N];
    logic [63:0] m_v1  [N], m_v2 [N];
    logic [5:0]  m_op  [N];
    logic [6:0]  m_fn  [N];
    logic [1:0]  m_rob [N];

    typedef struct {
        logic [5:0]  op;
        logic [6:0]  fn;
        logic [63:0] a, b;
        logic [3:0]  tag;
        logic [1:0]  rob;
    } txn_t;
    txn_t exp_q[$];

    function automatic int m_free();
        for (int i = 0; i < N; i++) if (m_st[i] == S_FREE) return i + 1;
        return 0;
    endfunction

    function automatic int m_sel();
        for (int i = 0; i < N; i++) if (m_st[i] == S_READY) return i;
        return -1;
    endfunction

    function automatic logic hit(input logic [3:0] t, input logic cv, input logic [3:0] ct);
        return (t != 4'd0) && cv && (t == ct);
    endfunction

    // One clock cycle: check visible outputs against the model, drive inputs,
    // advance the model, then wait for the edge.
    task automatic step(input logic iv, input logic [5:0] op, input logic [6:0] fn,
                        input logic [1:0] rob, input logic [3:0] t1, input logic [63:0] v1,
                        input logic [3:0] t2, input logic [63:0] v2,
                        input logic cv, input logic [3:0] ct, input logic [63:0] cval,
                        input logic fl, input logic fr);
        int   ft, sel, e;
        int   old [N];
        txn_t t;
        ft  = m_free();
        sel = m_sel();
        check("free_tag", 64'(free_tag), 64'(ft));
        check("fu_valid", 64'(fu_valid), 64'(sel >= 0));
        if (sel >= 0) check("fu_tag", 64'(fu_tag), 64'(sel + 1));
        if (sel >= 0 && fr) begin
            t.op = m_op[sel]; t.fn = m_fn[sel]; t.a = m_v1[sel]; t.b = m_v2[sel];
            t.tag = 4'(sel + 1); t.rob = m_rob[sel];
            exp_q.push_back(t);
        end
        issue_valid = iv; issue_opcode = op; issue_funct = fn; issue_rob_slot = rob;
        src1_tag = t1; src1_val = v1; src2_tag = t2; src2_val = v2;
        cdb_valid = cv; cdb_tag = ct; cdb_val = cval; flush = fl; fu_ready = fr;
        if (fl) begin
            for (int i = 0; i < N; i++) m_st[i] = S_FREE;
        end else begin
            old = m_st;
            if (sel >= 0 && fr) m_st[sel] = S_EXEC;
            for (int i = 0; i < N; i++) begin
                if (old[i] == S_EXEC && cv && ct == 4'(i + 1)) m_st[i] = S_FREE;
                if (old[i] == S_WAIT) begin
                    if (hit(m_t1[i], cv, ct)) begin m_t1[i] = 4'd0; m_v1[i] = cval; end
                    if (hit(m_t2[i], cv, ct)) begin m_t2[i] = 4'd0; m_v2[i] = cval; end
                    if (m_t1[i] == 4'd0 && m_t2[i] == 4'd0) m_st[i] = S_READY;
                end
            end
            if (iv && ft != 0) begin
                e = ft - 1;
                m_op[e] = op; m_fn[e] = fn; m_rob[e] = rob;
                m_t1[e] = hit(t1, cv, ct) ? 4'd0 : t1;
                m_v1[e] = hit(t1, cv, ct) ? cval : v1;
                m_t2[e] = hit(t2, cv, ct) ? 4'd0 : t2;
                m_v2[e] = hit(t2, cv, ct) ? cval : v2;
                m_st[e] = (m_t1[e] == 4'd0 && m_t2[e] == 4'd0) ? S_READY : S_WAIT;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic fr);
        step(0, '0, '0, '0, '0, '0, '0, '0, 0, '0, '0, 0, fr);
    endtask

    task automatic cdb(input logic [3:0] ct, input logic [63:0] cval, input logic fr);
        step(0, '0, '0, '0, '0, '0, '0, '0, 1, ct, cval, 0, fr);
    endtask

    task automatic do_flush();
        step(0, '0, '0, '0, '0, '0, '0, '0, 0, '0, '0, 1, 0);
    endtask

    // ---------------- monitor: consumes dispatch handshakes ----------------
    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (fu_valid && fu_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dispatch_unexpected: got tag %0h expected no dispatch", fu_tag);
                    end else begin
                        t = exp_q.pop_front();
                        check("disp_opcode", 64'(fu_opcode), 64'(t.op));
                        check("disp_funct", 64'(fu_funct), 64'(t.fn));
                        check("disp_a", fu_a, t.a);
                        check("disp_b", fu_b, t.b);
                        check("disp_tag", 64'(fu_tag), 64'(t.tag));
                        check("disp_rob", 64'(fu_rob_slot), 64'(t.rob));
                    end
                end else if (!fu_valid) begin
                    check("idle_outputs_zero",
                          64'(|{fu_opcode, fu_funct, fu_a, fu_b, fu_tag, fu_rob_slot}), 64'd0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < N; i++) m_st[i] = S_FREE;
        repeat (2) @(posedge clk);
        #1;
        check("reset_free_tag", 64'(free_tag), 64'd1);
        check("reset_fu_valid", 64'(fu_valid), 64'd0);
        check("reset_fu_a", fu_a, 64'd0);
        check("reset_fu_tag", 64'(fu_tag), 64'd0);
        rst_n = 1'b1;

        // Ready-at-issue addq: visible one cycle later.
        step(1, OP_INTA, FN_ADDQ, 2'd2, 4'd0, 64'd5, 4'd0, 64'd7, 0, '0, '0, 0, 1);
        check("t1_fu_valid", 64'(fu_valid), 64'd1);
        check("t1_fu_a", fu_a, 64'd5);
        check("t1_fu_b", fu_b, 64'd7);
        check("t1_fu_tag", 64'(fu_tag), 64'd1);
        check("t1_fu_rob", 64'(fu_rob_slot), 64'd2);
        check("t1_free_tag", 64'(free_tag), 64'd2);
        idle(1);
        cdb(4'd1, 64'd12, 1);
        do_flush();

        // Wakeup from the CDB two cycles after issue.
        step(1, OP_INTA, FN_SUBQ, 2'd1, 4'd4, 64'd0, 4'd0, 64'd3, 0, '0, '0, 0, 1);
        idle(1);
        check("t2_wait_fu_valid", 64'(fu_valid), 64'd0);
        cdb(4'd4, 64'h10, 1);
        check("t2_wake_fu_valid", 64'(fu_valid), 64'd1);
        check("t2_wake_fu_a", fu_a, 64'h10);
        idle(1);
        do_flush();

        // Fill the bank with fu_ready low.
        for (int i = 0; i < N; i++)
            step(1, OP_INTA, FN_ADDQ, 2'(i), 4'd0, 64'(100 + i), 4'd0, 64'(200 + i), 0, '0, '0, 0, 0);
        check("t3_full_free_tag", 64'(free_tag), 64'd0);
        step(1, OP_JMP, '0, 2'd3, 4'd0, 64'hbad, 4'd0, 64'hbad, 0, '0, '0, 0, 0);
        check("t3_ignored_free_tag", 64'(free_tag), 64'd0);
        check("t3_ignored_fu_a", fu_a, 64'd100);
        cdb(4'd1, 64'hdead, 0);
        check("t3_ready_not_freed", 64'(free_tag), 64'd0);
        check("t3_ready_held_tag", 64'(fu_tag), 64'd1);

        // Dispatch entry 1, release it, reuse tag 1 the next cycle.
        idle(1);
        cdb(4'd1, 64'd300, 0);
        check("t4_released_free_tag", 64'(free_tag), 64'd1);
        step(1, OP_BEQ, '0, 2'd3, 4'd0, 64'h77, 4'd0, 64'h88, 0, '0, '0, 0, 0);
        check("t4_reuse_fu_tag", 64'(fu_tag), 64'd1);
        check("t4_reuse_fu_a", fu_a, 64'h77);
        check("t4_reuse_free_tag", 64'(free_tag), 64'd0);
        do_flush();

        // Same-cycle CDB bypass at issue.
        step(1, OP_INTA, FN_ADDQ, 2'd1, 4'd0, 64'd4, 4'd5, 64'd0, 1, 4'd5, 64'd9, 0, 0);
        check("t5_bypass_fu_valid", 64'(fu_valid), 64'd1);
        check("t5_bypass_fu_b", fu_b, 64'd9);
        do_flush();

        // Flush beats simultaneous issue and CDB.
        step(1, OP_INTA, FN_ADDQ, 2'd0, 4'd0, 64'd1, 4'd0, 64'd2, 0, '0, '0, 0, 0);
        step(1, OP_INTA, FN_SUBQ, 2'd1, 4'd6, 64'd0, 4'd0, 64'd2, 0, '0, '0, 0, 0);
        step(1, OP_INTA, FN_ADDQ, 2'd2, 4'd0, 64'd3, 4'd0, 64'd4, 1, 4'd6, 64'd5, 1, 1);
        check("t6_flush_free_tag", 64'(free_tag), 64'd1);
        check("t6_flush_fu_valid", 64'(fu_valid), 64'd0);
        idle(0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] t1, t2;
            t1 = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 8)) : 4'd0;
            t2 = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 8)) : 4'd0;
            step(1'($urandom_range(0, 1)), 6'($urandom), 7'($urandom), 2'($urandom),
                 t1, {$urandom, $urandom}, t2, {$urandom, $urandom},
                 1'($urandom_range(0, 1)), 4'($urandom_range(1, 8)), {$urandom, $urandom},
                 ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0));
        end
        idle(0);
        idle(0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
